// File: rtl/uart_frame_loader_if.sv
// Byte-stream and BRAM-write bundle for uart_frame_loader.
// master = UART/control side, slave = the loader itself.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              frame_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              frame_done;
    logic              busy;
    logic              timeout_err;
    logic              chk_err;
    logic [7:0]        overrun_cnt;

    modport master (
        output rx_data, rx_ready, frame_ack,
        input  mem_we, mem_addr, mem_din, frame_done, busy,
        input  timeout_err, chk_err, overrun_cnt
    );

    modport slave (
        input  rx_data, rx_ready, frame_ack,
        output mem_we, mem_addr, mem_din, frame_done, busy,
        output timeout_err, chk_err, overrun_cnt
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Loads one header-delimited UART frame into the input tensor BRAM and locks it until acked.
// Optional macro CHECKSUM_EN: frame carries a trailing 8-bit modular-sum byte that is verified.
module uart_frame_loader #(
    parameter int         N_BYTES        = 64,
    parameter int         ADDR_W         = 6,
    parameter logic [7:0] HEADER         = 8'h01,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         TO_W           = 20
) (
    input  logic               clk,
    input  logic               reset,
    uart_frame_loader_if.slave bus
);
    localparam int                DATA_W   = 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, HOLD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd3} state_t;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] b);
        return acc + b;
    endfunction

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                done_pend_q;
    logic                frame_done_q;
    logic                busy_q;
    logic                timeout_err_q;
    logic [7:0]          ovr_q;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q;
    logic                chk_err_q;
`endif

    logic [TO_W-1:0]     to_cnt_d;
    logic [ADDR_W-1:0]   idx_d;
    logic                to_expire;
    logic                hdr_seen;

    assign to_cnt_d  = to_cnt_q + TO_W'(1);
    assign idx_d     = idx_q + ADDR_W'(1);
    // Counter value k means k idle cycles have passed since the last accepted byte.
    assign to_expire = (to_cnt_d == TO_LAST);
    assign hdr_seen  = bus.rx_ready && (bus.rx_data == HEADER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            done_pend_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            ovr_q         <= '0;
`ifdef CHECKSUM_EN
            sum_q         <= '0;
            chk_err_q     <= 1'b0;
`endif
        end else begin
            mem_we_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            done_pend_q   <= 1'b0;
            frame_done_q  <= done_pend_q;
`ifdef CHECKSUM_EN
            chk_err_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (hdr_seen) begin
                        state_q  <= LOAD;
                        idx_q    <= '0;
                        to_cnt_q <= '0;
                        busy_q   <= 1'b1;
`ifdef CHECKSUM_EN
                        sum_q    <= '0;
`endif
                    end
                end

                LOAD: begin
                    if (bus.rx_ready) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= idx_q;
                        mem_din_q  <= bus.rx_data;
                        idx_q      <= idx_d;
                        to_cnt_q   <= '0;
`ifdef CHECKSUM_EN
                        sum_q      <= csum_add(sum_q, bus.rx_data);
`endif
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
`ifdef CHECKSUM_EN
                            state_q <= CHECK;
`else
                            // Pulse one cycle after the final write so the BRAM is settled.
                            state_q     <= HOLD;
                            done_pend_q <= 1'b1;
`endif
                        end
                    end else if (to_expire) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        idx_q         <= '0;
                        to_cnt_q      <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end

`ifdef CHECKSUM_EN
                CHECK: begin
                    if (bus.rx_ready) begin
                        to_cnt_q <= '0;
                        if (bus.rx_data == sum_q) begin
                            state_q      <= HOLD;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            chk_err_q <= 1'b1;
                        end
                    end else if (to_expire) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        idx_q         <= '0;
                        to_cnt_q      <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
`endif

                HOLD: begin
                    // A byte arriving with the ack is still dropped, never taken as a header.
                    if (bus.rx_ready) begin
                        ovr_q <= sat_inc8(ovr_q);
                    end
                    if (bus.frame_ack) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun_cnt = ovr_q;
`ifdef CHECKSUM_EN
    assign bus.chk_err     = chk_err_q;
`else
    assign bus.chk_err     = 1'b0;
`endif

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Sits directly upstream of the input tensor BRAM (64 x 8-bit) that feeds the first convolution stage.
- Consumes the byte stream from the basic UART receiver: rx_data plus a one-cycle rx_ready strobe.
- Detects a frame header, then writes N_BYTES payload bytes to sequential BRAM addresses and signals frame completion to the control unit.
- Write-protects the BRAM until the downstream stage acknowledges the frame, with inter-byte timeout and overrun accounting.

Parameters:
- N_BYTES, 64, payload bytes per frame (8x8 tensor)
- ADDR_W, 6, BRAM address width; N_BYTES <= 2**ADDR_W
- HEADER, 8'h01, byte value that starts a frame
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between payload bytes (10 ms @ 100 MHz)
- TO_W, 20, timeout counter width; 2**TO_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte, valid when rx_ready=1
- rx_ready  in  1  one-cycle strobe per received byte
- frame_ack  in  1  downstream done with BRAM contents; releases write lock
- mem_we  out  1  BRAM port-A write enable
- mem_addr  out  ADDR_W  BRAM port-A address
- mem_din  out  8  BRAM port-A write data
- frame_done  out  1  one-cycle pulse: full frame stored
- busy  out  1  frame in progress or awaiting ack
- timeout_err  out  1  one-cycle pulse: frame aborted on inter-byte timeout
- chk_err  out  1  one-cycle pulse: checksum mismatch (0 when CHECKSUM_EN undefined)
- overrun_cnt  out  8  saturating count of bytes dropped while locked

Behaviour:
- Reset: state=IDLE. All outputs, byte index, timeout counter, checksum accumulator and overrun_cnt are 0.
- All outputs are registered.
- States: IDLE, LOAD, CHECK (only when CHECKSUM_EN is defined), HOLD.
- IDLE:
  - rx_ready with rx_data==HEADER -> LOAD; byte index=0, timeout cleared, busy=1 next cycle.
  - Any other byte is ignored; no write.
- LOAD, on rx_ready at cycle t:
  - t+1: mem_we=1, mem_addr=index, mem_din=rx_data; index increments and timeout counter clears.
  - A HEADER value inside the payload is treated as data.
  - When index reaches N_BYTES-1:
    - Without CHECKSUM_EN: frame_done pulses at t+2, state=HOLD.
    - With CHECKSUM_EN: go to CHECK.
- Timeout:
  - In LOAD/CHECK the counter increments every cycle without rx_ready.
  - On reaching TIMEOUT_CYCLES-1: timeout_err pulses, state=IDLE, busy=0, index=0.
  - Partially written BRAM contents are left as-is; no frame_done.
- HOLD:
  - busy=1, mem_we never asserted.
  - Each rx_ready increments overrun_cnt, saturating at 255.
  - frame_ack=1 -> IDLE next cycle, busy=0.
  - frame_ack and rx_ready in the same cycle: the byte counts as overrun and is not treated as a header.
- frame_ack outside HOLD is ignored.
- mem_we is at most 1 cycle per rx_ready; no back-to-back writes are possible (UART byte spacing >> 1 cycle).
- Reset mid-frame aborts immediately; the next frame restarts at address 0.
- overrun_cnt clears only on reset.

Optional Feature:
- Macro: CHECKSUM_EN
- Defined:
  - After the last payload byte the block enters CHECK and waits for one extra byte, counted against the same timeout.
  - Expected value: 8-bit modular sum of all N_BYTES payload bytes, accumulated as they are written.
  - Match: frame_done pulses the cycle after the checksum byte's rx_ready, then HOLD.
  - Mismatch: chk_err pulses, state=IDLE, busy=0, no frame_done.
- Undefined: no CHECK state, no accumulator, chk_err tied 0.

Test Plan:
- Send 0x01 then bytes 0x00..0x3F (checksum 0xE0 appended if CHECKSUM_EN) -> 64 writes with mem_addr=k, mem_din=k, each 1 cycle after its rx_ready; exactly one frame_done; busy=1 until frame_ack.
- In IDLE send 0x55, 0x00, 0xFF -> no mem_we, busy=0, no pulses.
- TIMEOUT_CYCLES=100: header + 10 bytes, then silence -> timeout_err exactly 100 cycles after last rx_ready, state IDLE. A following full frame loads from address 0.
- After frame_done, send 3 bytes -> no mem_we, overrun_cnt=3. Then frame_ack -> busy=0 next cycle; a new header is accepted.
- Assert reset after 30 payload bytes -> all outputs 0. A new frame writes starting at mem_addr=0.
- CHECKSUM_EN: payload 0x00..0x3F with checksum 0xE0 -> frame_done. Repeat with 0xE1 -> chk_err pulse, no frame_done, busy=0.
